// File: rtl/rr_sel_pkg.sv
// Shared types and helpers for the round-robin mux-select arbiter.
package rr_sel_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // One-hot grant vector for a mux select value.
   function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
      onehot = N_REQ'(1) << s;
   endfunction

endpackage

// File: rtl/rr_sel_arbiter_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping 3->0.
module rr_pick
   import rr_sel_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   logic [SEL_W-1:0] cand;

   // Scan farthest offset first so the nearest request to ptr wins.
   always_comb begin
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select with burst hold and valid/ready.
module rr_sel_arbiter
   import rr_sel_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned CNT_W     = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             ready,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] gnt,
   output logic             valid,
   output logic             last
);

   state_t           state, state_n;
   logic [SEL_W-1:0] sel_n;
   logic [N_REQ-1:0] gnt_n;
   logic             valid_n;
   logic [SEL_W-1:0] ptr, ptr_n;
   logic [CNT_W-1:0] cnt, cnt_n;

   logic [SEL_W-1:0] pick_ptr;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic             burst_end;
   logic             xfer;

   // In a burst the only re-pick happens at its end, from the slot after sel.
   assign pick_ptr  = (state == GRANT) ? sel + SEL_W'(1) : ptr;
   assign burst_end = (cnt == CNT_W'(MAX_BURST - 1)) || !req[sel];
   assign xfer      = valid && ready;
   assign last      = valid && burst_end;

   rr_pick u_pick (
      .req (req),
      .ptr (pick_ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sel   <= '0;
         gnt   <= '0;
         valid <= 1'b0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         sel   <= sel_n;
         gnt   <= gnt_n;
         valid <= valid_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
      end
   end

   // Next-state: grant from idle, count beats, rotate and re-pick at burst end.
   always_comb begin
      state_n = state;
      sel_n   = sel;
      gnt_n   = gnt;
      valid_n = valid;
      ptr_n   = ptr;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_n = GRANT;
               sel_n   = pick_idx;
               gnt_n   = onehot(pick_idx);
               valid_n = 1'b1;
               cnt_n   = '0;
            end else begin
               gnt_n   = '0;
               valid_n = 1'b0;
            end
         end
         GRANT: begin
            if (xfer) begin
               if (!burst_end) begin
                  cnt_n = cnt + CNT_W'(1);
               end else begin
                  ptr_n = sel + SEL_W'(1);
                  cnt_n = '0;
                  if (pick_any) begin
                     sel_n = pick_idx;
                     gnt_n = onehot(pick_idx);
                  end else begin
                     state_n = IDLE;
                     gnt_n   = '0;
                     valid_n = 1'b0;
                  end
               end
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
            valid_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench: two arbiters (burst 4 and burst 1) on shared stimulus.
module tb_rr_sel_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       ready;
   logic [1:0] sel4, sel1;
   logic [3:0] gnt4, gnt1;
   logic       valid4, valid1, last4, last1;

   int n_cmp;
   int n_bad;

   rr_sel_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .req(req), .ready(ready),
      .sel(sel4), .gnt(gnt4), .valid(valid4), .last(last4)
   );

   rr_sel_arbiter #(.MAX_BURST(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .req(req), .ready(ready),
      .sel(sel1), .gnt(gnt1), .valid(valid1), .last(last1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural reference: who is being served, beats served, rotation start.
   typedef struct {
      int busy;
      int who;
      int ptr;
      int beats;
   } model_t;

   model_t m4, m1;

   function automatic int first_req(input logic [3:0] r, input int start);
      for (int off = 0; off < 4; off++) begin
         if (r[(start + off) % 4]) return (start + off) % 4;
      end
      return -1;
   endfunction

   function automatic model_t model_reset();
      model_t z;
      z.busy = 0; z.who = 0; z.ptr = 0; z.beats = 0;
      return z;
   endfunction

   function automatic model_t step(input model_t m, input logic [3:0] r,
                                   input logic rdy, input int mb);
      model_t n;
      int p;
      n = m;
      if (m.busy == 0) begin
         p = first_req(r, m.ptr);
         if (p >= 0) begin
            n.busy = 1; n.who = p; n.beats = 0;
         end
      end else if (rdy) begin
         if ((m.beats + 1 < mb) && r[m.who]) begin
            n.beats = m.beats + 1;
         end else begin
            n.ptr   = (m.who + 1) % 4;
            n.beats = 0;
            p = first_req(r, n.ptr);
            if (p >= 0) n.who = p;
            else n.busy = 0;
         end
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m4 <= model_reset();
         m1 <= model_reset();
      end else begin
         m4 <= step(m4, req, ready, 4);
         m1 <= step(m1, req, ready, 1);
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk4(input string tag, input logic [1:0] s, input logic [3:0] g,
                       input logic v, input logic l);
      cmp({tag, " sel4"},   32'(sel4),   32'(s));
      cmp({tag, " gnt4"},   32'(gnt4),   32'(g));
      cmp({tag, " valid4"}, 32'(valid4), 32'(v));
      cmp({tag, " last4"},  32'(last4),  32'(l));
   endtask

   task automatic chk1(input string tag, input logic [1:0] s, input logic [3:0] g,
                       input logic v, input logic l);
      cmp({tag, " sel1"},   32'(sel1),   32'(s));
      cmp({tag, " gnt1"},   32'(gnt1),   32'(g));
      cmp({tag, " valid1"}, 32'(valid1), 32'(v));
      cmp({tag, " last1"},  32'(last1),  32'(l));
   endtask

   // Compare both DUTs against the model; sel is only meaningful while busy or after idle hold.
   task automatic chk_models(input string tag);
      logic [3:0] g4, g1;
      logic       l4, l1;
      g4 = (m4.busy != 0) ? 4'(1 << m4.who) : 4'b0000;
      g1 = (m1.busy != 0) ? 4'(1 << m1.who) : 4'b0000;
      l4 = (m4.busy != 0) && ((m4.beats == 3) || !req[m4.who]);
      l1 = (m1.busy != 0);
      chk4(tag, 2'(m4.who), g4, 1'(m4.busy), l4);
      chk1(tag, 2'(m1.who), g1, 1'(m1.busy), l1);
   endtask

   typedef struct {
      logic [3:0] req;
      logic       ready;
      logic [1:0] sel;
      logic [3:0] gnt;
      logic       valid;
      logic       last;
   } vec_t;

   vec_t tbl[25];

   initial begin
      // Directed table for the burst-4 arbiter, starting from a fresh reset.
      tbl[0]  = '{4'b0101, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
      tbl[1]  = '{4'b0101, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0};
      tbl[2]  = '{4'b0101, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0};
      tbl[3]  = '{4'b0101, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0};
      tbl[4]  = '{4'b0101, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1};
      tbl[5]  = '{4'b0101, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0};
      tbl[6]  = '{4'b0101, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0};
      tbl[7]  = '{4'b0101, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0};
      tbl[8]  = '{4'b0101, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1};
      tbl[9]  = '{4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1};
      tbl[10] = '{4'b0010, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
      tbl[11] = '{4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
      tbl[12] = '{4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
      tbl[13] = '{4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
      tbl[14] = '{4'b0010, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0};
      tbl[15] = '{4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
      tbl[16] = '{4'b0010, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0};
      tbl[17] = '{4'b0010, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0};
      tbl[18] = '{4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b1};
      tbl[19] = '{4'b1000, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1};
      tbl[20] = '{4'b1000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0};
      tbl[21] = '{4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1};
      tbl[22] = '{4'b0001, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0};
      tbl[23] = '{4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b1};
      tbl[24] = '{4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b1};

      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      req   = 4'b0000;
      ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Busy traffic, then asynchronous reset between edges.
      req = 4'b1111; ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      chk4("async_rst", 2'd0, 4'b0000, 1'b0, 1'b0);
      chk1("async_rst", 2'd0, 4'b0000, 1'b0, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk4("rst_released", 2'd0, 4'b0000, 1'b0, 1'b0);
      @(posedge clk); #1;

      // Burst 1 rotates every beat; burst 4 holds in0 for four beats.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk1($sformatf("rr1_%0d", k), 2'(k % 4), 4'(1 << (k % 4)), 1'b1, 1'b1);
         chk4($sformatf("rr4_%0d", k), (k < 4) ? 2'd0 : 2'd1,
              (k < 4) ? 4'b0001 : 4'b0010, 1'b1, (k == 3));
         @(posedge clk); #1;
      end

      // Reset during beat 2 of a burst, then a full fresh burst from in0.
      #2 rst = 1'b1;
      #1;
      chk4("mid_rst", 2'd0, 4'b0000, 1'b0, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk4($sformatf("restart_%0d", j), 2'd0, 4'b0001, 1'b1, (j == 3));
         @(posedge clk); #1;
      end

      // Table run from a clean reset.
      req = 4'b0000; ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 25; i++) begin
         req   = tbl[i].req;
         ready = tbl[i].ready;
         @(negedge clk);
         chk4($sformatf("tbl_%0d", i), tbl[i].sel, tbl[i].gnt, tbl[i].valid, tbl[i].last);
         @(posedge clk); #1;
      end

      // Randomized traffic with occasional async resets, checked against the model.
      for (int c = 0; c < 3000; c++) begin
         req   = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
         ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) == 0) begin
            #2 rst = 1'b1;
            #1 rst = 1'b0;
         end
         @(negedge clk);
         chk_models($sformatf("rnd_%0d", c));
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
